// File: rtl/snn_neuron_core.sv
// Integrate-and-fire neuron: periodic pixel snapshot, serial weighted accumulation
// with saturation, then threshold fire or leak, plus a running spike counter.
module snn_neuron_core #(
    parameter int N_IN        = 7,
    parameter int W_WIDTH     = 9,
    parameter int ACC_WIDTH   = 16,
    parameter int STIM_PERIOD = 16,
    parameter int LEAK_SHIFT  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [N_IN-1:0]             pixels,
    input  logic                        w_we,
    input  logic [$clog2(N_IN)-1:0]     w_addr,
    input  logic signed [W_WIDTH-1:0]   w_data,
    input  logic signed [ACC_WIDTH-1:0] threshold,
    output logic                        busy,
    output logic                        neuron_out,
    output logic                        frame_done,
    output logic signed [ACC_WIDTH-1:0] potential,
    output logic [15:0]                 spike_count
);
    localparam int AW = $clog2(N_IN);
    localparam int CW = (STIM_PERIOD > 1) ? $clog2(STIM_PERIOD) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N_IN - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(STIM_PERIOD - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // A frame must finish before the next tick can start another one.
    generate
        if (STIM_PERIOD < N_IN + 2) begin : g_bad_period
            $error("snn_neuron_core: STIM_PERIOD must be >= N_IN+2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_t;

    state_t                      state;
    logic [CW-1:0]               tick_cnt;
    logic                        tick;
    logic [N_IN-1:0]             snap;
    logic [AW-1:0]               idx;
    logic signed [W_WIDTH-1:0]   weights [N_IN];
    logic signed [ACC_WIDTH:0]   sum_wide;
    logic signed [ACC_WIDTH-1:0] sum_sat;
    logic signed [ACC_WIDTH-1:0] leaked;

    assign tick = en && (tick_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (en) begin
            tick_cnt <= (tick_cnt == LAST_CNT) ? '0 : tick_cnt + CW'(1);
        end
    end

    // Out-of-range addresses are dropped rather than aliased onto a real weight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_IN; i++) begin
                weights[i] <= '0;
            end
        end else if (w_we && (w_addr <= LAST_IDX)) begin
            weights[w_addr] <= w_data;
        end
    end

    // One guard bit catches overflow; clamp instead of wrapping.
    always_comb begin
        sum_wide = (ACC_WIDTH+1)'(potential) + (ACC_WIDTH+1)'(weights[idx]);
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
            sum_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum_wide[ACC_WIDTH-1:0];
        end
    end

    always_comb begin
        if (LEAK_SHIFT == 0) begin
            leaked = potential;
        end else begin
            leaked = potential - (potential >>> LEAK_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            snap        <= '0;
            idx         <= '0;
            busy        <= 1'b0;
            neuron_out  <= 1'b0;
            frame_done  <= 1'b0;
            potential   <= '0;
            spike_count <= '0;
        end else begin
            neuron_out <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        snap  <= pixels;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (snap[idx]) begin
                        potential <= sum_sat;
                    end
                    if (idx == LAST_IDX) begin
                        state <= FIRE;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                FIRE: begin
                    if (potential >= threshold) begin
                        potential   <= '0;
                        neuron_out  <= 1'b1;
                        spike_count <= spike_count + 16'd1;
                    end else begin
                        potential <= leaked;
                    end
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snn_neuron_core.sv
// Bench for snn_neuron_core: table vectors, hand-written corner sequences and
// random frames checked against a frame-level arithmetic model.
module tb_snn_neuron_core;
    typedef int warr_t [7];

    typedef struct {
        string      name;
        warr_t      w;
        logic [6:0] pix;
        int         thr;
        int         frames;
        int         exp_pot;
        int         exp_spk;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst, en, w_we;
    logic [6:0]         pixels;
    logic [2:0]         w_addr;
    logic signed [8:0]  w_data;
    logic signed [15:0] thr_a, thr_b;

    logic               busy_a, neuron_out_a, frame_done_a;
    logic signed [15:0] potential_a;
    logic [15:0]        spike_count_a;
    logic               busy_b, neuron_out_b, frame_done_b;
    logic signed [15:0] potential_b;
    logic [15:0]        spike_count_b;

    int checks   = 0;
    int failures = 0;

    // Frame-level reference state
    int mw [7];
    int mpot_a, mpot_b, mspk_a, mspk_b;

    vec_t vecs [$];

    always #5 clk = ~clk;

    snn_neuron_core #(.LEAK_SHIFT(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .pixels(pixels),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .threshold(thr_a),
        .busy(busy_a), .neuron_out(neuron_out_a), .frame_done(frame_done_a),
        .potential(potential_a), .spike_count(spike_count_a)
    );

    snn_neuron_core #(.LEAK_SHIFT(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .pixels(pixels),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .threshold(thr_b),
        .busy(busy_b), .neuron_out(neuron_out_b), .frame_done(frame_done_b),
        .potential(potential_b), .spike_count(spike_count_b)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] pix, input int ta, input int tb_thr);
        pixels = pix;
        thr_a  = 16'(ta);
        thr_b  = 16'(tb_thr);
    endtask

    task automatic write_weight(input int addr, input int data);
        w_we   = 1'b1;
        w_addr = 3'(addr);
        w_data = 9'(data);
        @(negedge clk);
        w_we = 1'b0;
        if (addr < 7) mw[addr] = data;
    endtask

    task automatic write_all(input warr_t w);
        for (int i = 0; i < 7; i++) write_weight(i, w[i]);
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        en   = 1'b0;
        w_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 7; i++) mw[i] = 0;
        mpot_a = 0; mpot_b = 0; mspk_a = 0; mspk_b = 0;
    endtask

    task automatic wait_frame(output int cycles);
        int  n;
        bit  got;
        n = 0; got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (frame_done_a) got = 1'b1;
        end
        cycles = got ? n : -1;
    endtask

    task automatic wait_busy(output bit ok);
        int n;
        n = 0; ok = 1'b0;
        while (!ok && n < 40) begin
            @(negedge clk);
            n++;
            if (busy_a) ok = 1'b1;
        end
    endtask

    // One whole frame: saturate after each add, then fire or leak.
    task automatic model_frame(input int w[7], input logic [6:0] snap, input int thr,
                               input int leak, inout int pot, inout int spk,
                               output bit fired);
        int acc;
        acc = pot;
        for (int i = 0; i < 7; i++) begin
            if (snap[i]) begin
                acc = acc + w[i];
                if (acc > 32767)  acc = 32767;
                if (acc < -32768) acc = -32768;
            end
        end
        if (acc >= thr) begin
            pot   = 0;
            spk   = (spk + 1) % 65536;
            fired = 1'b1;
        end else begin
            fired = 1'b0;
            pot   = (leak == 0) ? acc : acc - (acc >>> leak);
        end
    endtask

    task automatic check_frame(input string tag, input logic [6:0] snap,
                               input int ta, input int tb_thr, input bit check_b);
        bit fa, fb;
        model_frame(mw, snap, ta, 0, mpot_a, mspk_a, fa);
        model_frame(mw, snap, tb_thr, 1, mpot_b, mspk_b, fb);
        checkOutput({tag, "_nout_a"}, neuron_out_a, fa);
        checkOutput({tag, "_pot_a"}, potential_a, mpot_a);
        checkOutput({tag, "_spk_a"}, spike_count_a, mspk_a);
        if (check_b) begin
            checkOutput({tag, "_fdone_b"}, frame_done_b, 1);
            checkOutput({tag, "_nout_b"}, neuron_out_b, fb);
            checkOutput({tag, "_pot_b"}, potential_b, mpot_b);
            checkOutput({tag, "_spk_b"}, spike_count_b, mspk_b);
        end
    endtask

    task automatic add_vec(input string nm, input warr_t w, input logic [6:0] pix,
                           input int thr, input int frames, input int pot, input int spk);
        vec_t v;
        v.name = nm; v.w = w; v.pix = pix; v.thr = thr;
        v.frames = frames; v.exp_pot = pot; v.exp_spk = spk;
        vecs.push_back(v);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        warr_t w60, wneg, w255, wramp;
        int    cyc, cnt, nz;
        bit    ok;
        logic [6:0] snap;
        int    ta, tbt;
        int    leak_exp [3];

        for (int i = 0; i < 7; i++) begin
            w60[i]   = 60;
            wneg[i]  = 0;
            w255[i]  = 255;
            wramp[i] = i * 10 + 5;
        end
        wneg[1] = -200; wneg[3] = 60; wneg[5] = 60;
        leak_exp[0] = 90; leak_exp[1] = 135; leak_exp[2] = 158;

        add_vec("fire_f1",  w60,  7'b0101010, 300,   1,  180,   0);
        add_vec("fire_f2",  w60,  7'b0101010, 300,   2,  0,     1);
        add_vec("fire_f4",  w60,  7'b0101010, 300,   4,  0,     2);
        add_vec("neg_f3",   wneg, 7'b0101010, 1,     3,  -240,  0);
        add_vec("neg_f10",  wneg, 7'b0101010, 1,     10, -800,  0);
        add_vec("sat_f18",  w255, 7'b1111111, 32767, 18, 32130, 0);
        add_vec("sat_f19",  w255, 7'b1111111, 32767, 19, 0,     1);

        rst = 1'b0; en = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
        pixels = '0; thr_a = '0; thr_b = '0;
        @(negedge clk);
        do_reset();
        checkOutput("rst_busy",  busy_a, 0);
        checkOutput("rst_nout",  neuron_out_a, 0);
        checkOutput("rst_fdone", frame_done_a, 0);
        checkOutput("rst_pot",   potential_a, 0);
        checkOutput("rst_spk",   spike_count_a, 0);

        // Zero weights: nothing can accumulate or fire
        applyStimulus(7'b1111111, 100, 100);
        en = 1'b1;
        cnt = 0; nz = 0;
        repeat (200) begin
            @(negedge clk);
            if (neuron_out_a) cnt++;
            if (potential_a != 0) nz++;
        end
        checkOutput("idle_spikes", cnt, 0);
        checkOutput("idle_pot_nonzero", nz, 0);
        checkOutput("idle_spk", spike_count_a, 0);

        foreach (vecs[v]) begin
            do_reset();
            write_all(vecs[v].w);
            applyStimulus(vecs[v].pix, vecs[v].thr, vecs[v].thr);
            en = 1'b1;
            for (int f = 0; f < vecs[v].frames; f++) begin
                wait_frame(cyc);
                checkOutput({vecs[v].name, "_latency"}, cyc, (f == 0) ? 24 : 16);
                check_frame(vecs[v].name, vecs[v].pix, vecs[v].thr, vecs[v].thr, 1'b0);
            end
            checkOutput({vecs[v].name, "_final_pot"}, potential_a, vecs[v].exp_pot);
            checkOutput({vecs[v].name, "_final_spk"}, spike_count_a, vecs[v].exp_spk);
        end

        // Leaky instance: 180 per frame, halved remainder kept
        do_reset();
        write_all(w60);
        applyStimulus(7'b0101010, 1000, 1000);
        en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            wait_frame(cyc);
            checkOutput("leak_frame_seen", (cyc > 0) ? 1 : 0, 1);
            if (f < 3) checkOutput("leak_pot_hand", potential_b, leak_exp[f]);
            check_frame("leak", 7'b0101010, 1000, 1000, 1'b1);
        end

        // Reset in the middle of accumulation
        do_reset();
        write_all(w60);
        applyStimulus(7'b1111111, 30000, 30000);
        en = 1'b1;
        wait_busy(ok);
        checkOutput("midrst_busy_seen", ok, 1);
        repeat (3) @(negedge clk);
        checkOutput("midrst_pre_pot", potential_a, 180);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", busy_a, 0);
        checkOutput("midrst_pot", potential_a, 0);
        checkOutput("midrst_fdone", frame_done_a, 0);
        rst = 1'b1; en = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (frame_done_a) cnt++;
        end
        checkOutput("midrst_no_pulse", cnt, 0);
        en = 1'b1;
        wait_frame(cyc);
        checkOutput("midrst_weights_cleared", potential_a, 0);

        // Out-of-range write must not disturb any weight
        do_reset();
        write_all(wramp);
        write_weight(7, -1);
        applyStimulus(7'b1111111, 30000, 30000);
        en = 1'b1;
        wait_frame(cyc);
        checkOutput("addr7_pot", potential_a, 245);
        check_frame("addr7", 7'b1111111, 30000, 30000, 1'b1);

        // Writing the weight being read this cycle: old value is used
        do_reset();
        write_all(w60);
        applyStimulus(7'b1111111, 30000, 30000);
        en = 1'b1;
        wait_busy(ok);
        w_we = 1'b1; w_addr = 3'd0; w_data = 9'sd100;
        @(negedge clk);
        w_addr = 3'd1;
        @(negedge clk);
        w_we = 1'b0;
        wait_frame(cyc);
        checkOutput("rw_same_f1", potential_a, 420);
        wait_frame(cyc);
        checkOutput("rw_same_f2", potential_a, 920);

        // en dropping mid-frame and holding the tick counter
        do_reset();
        write_all(w60);
        applyStimulus(7'b0101010, 30000, 30000);
        en = 1'b1;
        wait_busy(ok);
        en = 1'b0;
        wait_frame(cyc);
        checkOutput("endrop_completes", cyc, 8);
        checkOutput("endrop_pot", potential_a, 180);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (frame_done_a || busy_a) cnt++;
        end
        checkOutput("endrop_quiet", cnt, 0);
        en = 1'b1;
        wait_frame(cyc);
        checkOutput("endrop_resume", cyc, 24);
        checkOutput("endrop_pot2", potential_a, 360);
        en = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1;
        wait_frame(cyc);
        checkOutput("enhold_phase", cyc, 16);
        checkOutput("enhold_pot3", potential_a, 540);

        // Random frames with pixel scrambling after the snapshot
        do_reset();
        en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            snap = 7'($urandom);
            ta   = int'($urandom_range(0, 6000)) - 2000;
            tbt  = int'($urandom_range(0, 6000)) - 2000;
            applyStimulus(snap, ta, tbt);
            write_weight(int'($urandom_range(0, 7)), int'($urandom_range(0, 511)) - 256);
            write_weight(int'($urandom_range(0, 7)), int'($urandom_range(0, 511)) - 256);
            wait_busy(ok);
            pixels = 7'($urandom);
            wait_frame(cyc);
            checkOutput("rand_frame_seen", (cyc > 0) ? 1 : 0, 1);
            check_frame("rand", snap, ta, tbt, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
